// File: rtl/templatized_alu_sequencer.sv
// templatized_alu_sequencer
//
// Command front-end for the templatized ALU. Requests (opcode plus two
// operands) are buffered in a DEPTH-entry FIFO. They are issued one at a
// time to the ALU datapath. Results return in request order over a
// response port.
//
// Handshakes: a transfer happens on the rising clk edge where valid and
// ready are both 1. A valid side holds its payload stable until that
// edge. req_ready depends only on FIFO occupancy. rsp_valid, rsp_result
// and rsp_err stay stable until rsp_ready is seen.
//
// Optional feature: define TEMPLATIZED_ALU_SEQ_TIMEOUT_EN to abort WAIT
// after 16 cycles without alu_done. The aborted operation gets an error
// response.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_op, req_a, req_b            opcode and operands
//   alu_valid                       one-cycle issue pulse
//   alu_op_code, alu_a, alu_b       registered issue payload
//   alu_done, alu_result            datapath completion pulse and result
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_err             result (0 on error) and error flag
//   dbg_state                       current FSM state, for observation only
module templatized_alu_sequencer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             alu_valid,
    output logic [3:0]       alu_op_code,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic [1:0]       dbg_state
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Request FIFO storage
    logic [3:0]       fifo_op_q [DEPTH];
    logic [WIDTH-1:0] fifo_a_q  [DEPTH];
    logic [WIDTH-1:0] fifo_b_q  [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;

    logic push, pop, head_legal, timeout;
    logic [3:0]       head_op;
    logic [WIDTH-1:0] head_a, head_b;

    logic [3:0]       alu_op_code_q, alu_op_code_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_err_q, rsp_err_d;

    assign req_ready  = (count_q != DEPTH[AW:0]);
    assign push       = req_valid && req_ready;
    // The head is consumed whenever IDLE sees a non-empty FIFO, whether it
    // is legal (goes to ISSUE) or illegal (answered locally).
    assign pop        = (state_q == IDLE) && (count_q != '0);
    assign head_op    = fifo_op_q[rd_ptr_q];
    assign head_a     = fifo_a_q[rd_ptr_q];
    assign head_b     = fifo_b_q[rd_ptr_q];
    assign head_legal = (head_op <= 4'd8);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op_q[wr_ptr_q] <= req_op;
            fifo_a_q[wr_ptr_q]  <= req_a;
            fifo_b_q[wr_ptr_q]  <= req_b;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

`ifdef TEMPLATIZED_ALU_SEQ_TIMEOUT_EN
    // The counter is zero in every state except WAIT, so it is cleared on
    // entry to WAIT. A value of 15 marks the 16th WAIT cycle.
    logic [3:0] wait_cnt_q, wait_cnt_d;

    assign wait_cnt_d = (state_q == WAIT) ? wait_cnt_q + 4'd1 : 4'd0;
    assign timeout    = (state_q == WAIT) && (wait_cnt_q == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt_q <= 4'd0;
        else        wait_cnt_q <= wait_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        alu_op_code_d = alu_op_code_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        rsp_result_d  = rsp_result_q;
        rsp_err_d     = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    if (head_legal) begin
                        state_d       = ISSUE;
                        alu_op_code_d = head_op;
                        alu_a_d       = head_a;
                        alu_b_d       = head_b;
                    end else begin
                        state_d      = RESP;
                        rsp_result_d = '0;
                        rsp_err_d    = 1'b1;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // alu_done wins over a timeout expiring in the same cycle.
                if (alu_done) begin
                    state_d      = RESP;
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                end else if (timeout) begin
                    state_d      = RESP;
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                end
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            alu_op_code_q <= 4'd0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            rsp_result_q  <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_op_code_q <= alu_op_code_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            rsp_result_q  <= rsp_result_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign alu_valid   = (state_q == ISSUE);
    assign alu_op_code = alu_op_code_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_result  = rsp_result_q;
    assign rsp_err     = rsp_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_templatized_alu_sequencer.sv
// Testbench for templatized_alu_sequencer.
module tb_templatized_alu_sequencer;
  localparam int W = 32;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_ready;
  logic [3:0]    req_op = '0;
  logic [W-1:0]  req_a = '0, req_b = '0;
  logic          alu_valid, alu_done;
  logic [3:0]    alu_op_code;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [W-1:0]  rsp_result;
  logic [1:0]    dbg_state;

  templatized_alu_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_valid(alu_valid), .alu_op_code(alu_op_code), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [W:0]     exp_q[$];   // {err, result} in request order
  logic [W*2+3:0] iss_q[$];   // {op, a, b} of legal requests, issue order

  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    s = int'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return (a < b) ? 1 : 0;
      4'd3: return (a > b) ? 1 : 0;
      4'd4: return a ^ b;
      4'd5: return a << s;
      4'd6: return W'($signed(a) >>> s);
      4'd7: return (s == 0) ? a : ((a << s) | (a >> (W - s)));
      4'd8: return (s == 0) ? a : ((a >> s) | (a << (W - s)));
      default: return '0;
    endcase
  endfunction

  // ---------------- ALU datapath model ----------------
  bit alu_en = 1'b1;
  int alu_lat = 1;
  int pulses = 0;
  int last_iss_cyc = 0, prev_iss_cyc = 0;

  initial begin
    logic [W*2+3:0] e;
    alu_done = 1'b0;
    alu_result = '0;
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      if (alu_valid) begin
        pulses++;
        prev_iss_cyc = last_iss_cyc;
        last_iss_cyc = cyc;
        checks++;
        if (iss_q.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected: got op=%h a=%h b=%h, required no issue", alu_op_code, alu_a, alu_b);
        end else begin
          e = iss_q.pop_front();
          if ({alu_op_code, alu_a, alu_b} !== e) begin
            errors++;
            $display("FAIL issue_payload: got %h/%h/%h, required %h/%h/%h",
                     alu_op_code, alu_a, alu_b, e[W*2+3:W*2], e[W*2-1:W], e[W-1:0]);
          end
        end
        if (alu_en) begin
          e = {alu_op_code, alu_a, alu_b};
          repeat (alu_lat) @(negedge clk);
          alu_done = 1'b1;
          alu_result = alu_fn(e[W*2+3:W*2], e[W*2-1:W], e[W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    while (!req_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout: req_ready=%b, required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (op <= 4'd8) begin
      exp_q.push_back({1'b0, alu_fn(op, a, b)});
      iss_q.push_back({op, a, b});
    end else begin
      exp_q.push_back({1'b1, {W{1'b0}}});
    end
  endtask

  task automatic collect(input int n, input bit rand_ready);
    logic [W:0] e;
    for (int k = 0; k < n; k++) begin
      int t = 0;
      bit got = 0;
      while (!got && t < 300) begin
        @(negedge clk);
        t++;
        rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (rsp_valid && rsp_ready) begin
          got = 1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got result=%h err=%b, required none", rsp_result, rsp_err);
          end else begin
            e = exp_q.pop_front();
            if ({rsp_err, rsp_result} !== e) begin
              errors++;
              $display("FAIL rsp_data: got result=%h err=%b, required result=%h err=%b",
                       rsp_result, rsp_err, e[W-1:0], e[W]);
            end
          end
        end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL rsp_timeout: rsp_valid=%b, required 1", rsp_valid);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    iss_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({req_ready, alu_valid, alu_op_code, alu_a, alu_b, rsp_valid, rsp_result, rsp_err} !==
        {1'b1, 1'b0, 4'd0, {W{1'b0}}, {W{1'b0}}, 1'b0, {W{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b av=%b op=%h a=%h b=%h rv=%b res=%h err=%b, required 1 0 0 0 0 0 0 0",
               req_ready, alu_valid, alu_op_code, alu_a, alu_b, rsp_valid, rsp_result, rsp_err);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({req_ready, alu_valid, rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL idle_after_reset: got rdy=%b av=%b rv=%b, required 1 0 0", req_ready, alu_valid, rsp_valid);
    end
  endtask

  task automatic test_add();
    send_req(4'd0, 5, 7);
    checks++;
    if ({alu_valid, rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL add_n: got av=%b rv=%b, required 0 0", alu_valid, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if ({alu_valid, alu_op_code, alu_a, alu_b} !== {1'b1, 4'd0, W'(5), W'(7)}) begin
      errors++;
      $display("FAIL add_issue: got av=%b op=%h a=%0d b=%0d, required 1 0 5 7", alu_valid, alu_op_code, alu_a, alu_b);
    end
    @(negedge clk);
    checks++;
    if ({alu_valid, rsp_valid, alu_op_code, alu_a} !== {1'b0, 1'b0, 4'd0, W'(5)}) begin
      errors++;
      $display("FAIL add_wait: got av=%b rv=%b op=%h a=%0d, required 0 0 0 5", alu_valid, rsp_valid, alu_op_code, alu_a);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_rsp_latency: got rsp_valid=%b, required 1", rsp_valid);
    end
    collect(1, 1'b0);
  endtask

  task automatic test_illegal();
    int p0;
    send_req(4'hC, 3, 3);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_early: got rsp_valid=%b, required 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, alu_valid} !== 2'b10) begin
      errors++;
      $display("FAIL illegal_latency: got rv=%b av=%b, required 1 0", rsp_valid, alu_valid);
    end
    collect(1, 1'b0);
    p0 = pulses;
    send_req(4'd1, 9, 4);
    send_req(4'hA, 1, 2);
    send_req(4'd4, 32'hF0, 32'h0F);
    collect(3, 1'b1);
    checks++;
    if (pulses - p0 !== 2) begin
      errors++;
      $display("FAIL illegal_pulses: got %0d alu_valid pulses, required 2", pulses - p0);
    end
  endtask

  task automatic test_fill();
    rsp_ready = 1'b0;
    for (int i = 0; i < D + 1; i++) send_req(4'($urandom_range(0, 8)), $urandom, $urandom);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready: got req_ready=%b, required 0", req_ready);
    end
    req_valid = 1'b1; req_op = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_refuse: got req_ready=%b, required 0", req_ready);
      end
    end
    req_valid = 1'b0;
    collect(D + 1, 1'b1);
  endtask

  task automatic test_hold();
    int t = 0;
    send_req(4'd7, $urandom, 5);
    while (!rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, alu_valid, rsp_err, rsp_result} !== {1'b1, 1'b0, exp_q[0]}) begin
        errors++;
        $display("FAIL rsp_hold: got rv=%b av=%b err=%b res=%h, required 1 0 %b %h",
                 rsp_valid, alu_valid, rsp_err, rsp_result, exp_q[0][W], exp_q[0][W-1:0]);
      end
      @(negedge clk);
    end
    collect(1, 1'b0);
  endtask

  task automatic test_back_to_back();
    fork
      begin
        send_req(4'd0, 1, 2);
        send_req(4'd1, 10, 3);
      end
      collect(2, 1'b0);
    join
    checks++;
    if (last_iss_cyc - prev_iss_cyc !== 4) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles between issues, required 4", last_iss_cyc - prev_iss_cyc);
    end
  endtask

  task automatic test_random();
    fork
      for (int i = 0; i < 24; i++) begin
        alu_lat = $urandom_range(1, 4);
        send_req(4'($urandom_range(0, 15)), $urandom, $urandom);
      end
      collect(24, 1'b1);
    join
    alu_lat = 1;
  endtask

  task automatic test_reset_mid_op();
    alu_lat = 3;
    send_req(4'd0, 11, 22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, alu_valid, rsp_valid, alu_op_code, alu_a} !== {3'b100, 4'd0, {W{1'b0}}}) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b av=%b rv=%b op=%h a=%h, required 1 0 0 0 0",
               req_ready, alu_valid, rsp_valid, alu_op_code, alu_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    iss_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, alu_valid} !== 2'b00) begin
        errors++;
        $display("FAIL late_done_ignored: got rv=%b av=%b, required 0 0", rsp_valid, alu_valid);
      end
    end
    alu_lat = 1;
  endtask

  task automatic test_timeout();
    alu_en = 1'b0;
    send_req(4'd0, 3, 4);
`ifdef TEMPLATIZED_ALU_SEQ_TIMEOUT_EN
    repeat (17) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got rsp_valid=%b, required 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_result} !== {2'b11, {W{1'b0}}}) begin
      errors++;
      $display("FAIL timeout_rsp: got rv=%b err=%b res=%h, required 1 1 0", rsp_valid, rsp_err, rsp_result);
    end
    void'(exp_q.pop_front());
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
`else
    repeat (100) @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL wait_forever: got rv=%b rdy=%b, required 0 1", rsp_valid, req_ready);
    end
`endif
    pulse_reset();
    @(negedge clk);
    checks++;
    if ({rsp_valid, alu_valid, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL timeout_reset: got rv=%b av=%b rdy=%b, required 0 0 1", rsp_valid, alu_valid, req_ready);
    end
    alu_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_illegal();
    test_fill();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    test_timeout();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d pending responses, required 0", exp_q.size());
    end
    $display("final dbg_state=%0d", dbg_state);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation ran past its time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
